// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue unit: opcodes, field layout of the
// 16-bit instruction word, and helpers to encode words and inspect their registers.
package instr_issue_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_ANDI = 3'b011;
    localparam logic [2:0] OP_ORI  = 3'b100;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RS_MSB  = 12;
    localparam int RS_LSB  = 10;
    localparam int RT_MSB  = 9;
    localparam int RT_LSB  = 7;
    localparam int RD_MSB  = 6;
    localparam int RD_LSB  = 4;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    // ori R0,R0,0 leaves every register untouched, so it is a safe filler.
    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h8000;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [5:0] imm;
    } instrFields_t;

    function automatic logic is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_ANDI, OP_ORI: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_rtype(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // R-type carries rd in [6:4] with a zero low nibble; I-type keeps bit 6 clear.
    function automatic logic [15:0] encode(input instrFields_t f);
        logic [15:0] w;
        w = '0;
        w[OP_MSB:OP_LSB] = f.op;
        w[RS_MSB:RS_LSB] = f.rs;
        w[RT_MSB:RT_LSB] = f.rt;
        if (is_rtype(f.op)) begin
            w[RD_MSB:RD_LSB] = f.rd;
        end else begin
            w[IMM_MSB:IMM_LSB] = f.imm;
        end
        return w;
    endfunction

    function automatic logic [2:0] dst_of(input logic [15:0] w);
        return is_rtype(w[OP_MSB:OP_LSB]) ? w[RD_MSB:RD_LSB] : w[RT_MSB:RT_LSB];
    endfunction

    function automatic logic reads_reg(input logic [15:0] w, input logic [2:0] r);
        return (w[RS_MSB:RS_LSB] == r) ||
               (is_rtype(w[OP_MSB:OP_LSB]) && (w[RT_MSB:RT_LSB] == r));
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular word buffer with occupancy count; flush outranks push/pop, and a push
// while full or a pop while empty is ignored.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    assign rdData = mem[rdPtr];
    assign doPush = push & ~full & ~flush;
    assign doPop  = pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// Encodes host instruction fields, queues them, and issues one word per issue cycle.
// Optional read-after-write bubble insertion: define INSTR_ISSUE_HAZARD_BUBBLE_EN.
module instr_issue_unit
    import instr_issue_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [2:0]             in_rs,
    input  logic [2:0]             in_rt,
    input  logic [2:0]             in_rd,
    input  logic [5:0]             in_imm,
    input  logic                   issue_en,
    input  logic                   flush,
    output logic [15:0]            instr_out,
    output logic                   instr_valid,
    output logic                   illegal_op,
    output logic [$clog2(DEPTH):0] fifo_count
);

    instrFields_t fields;
    logic [15:0]  encWord;
    logic [15:0]  headWord;
    logic         opLegal;
    logic         accept;
    logic         fifoPush;
    logic         fifoPop;
    logic         fifoFull;
    logic         fifoEmpty;
    logic         hazardStall;
    logic         issueReal;

    assign fields.op  = in_op;
    assign fields.rs  = in_rs;
    assign fields.rt  = in_rt;
    assign fields.rd  = in_rd;
    assign fields.imm = in_imm;

    assign encWord   = encode(fields);
    assign opLegal   = is_legal(in_op);
    assign in_ready  = ~fifoFull;
    assign accept    = in_valid & in_ready;
    assign fifoPush  = accept & opLegal & ~flush;
    assign issueReal = issue_en & ~fifoEmpty & ~hazardStall;
    assign fifoPop   = issueReal & ~flush;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData (encWord),
        .rdData (headWord),
        .count  (fifo_count),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

`ifdef INSTR_ISSUE_HAZARD_BUBBLE_EN
    logic [2:0] lastDst;
    logic       lastDstVld;

    assign hazardStall = lastDstVld & reads_reg(headWord, lastDst);

    // Remember where the last real word writes; any NOP issue breaks the dependency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastDst    <= '0;
            lastDstVld <= 1'b0;
        end else if (flush) begin
            lastDstVld <= 1'b0;
        end else if (issue_en) begin
            if (issueReal) begin
                lastDst    <= dst_of(headWord);
                lastDstVld <= 1'b1;
            end else begin
                lastDstVld <= 1'b0;
            end
        end
    end
`else
    assign hazardStall = 1'b0;
`endif

    // Output register: head word when available, otherwise the NOP filler.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (flush) begin
            instr_out   <= NOP_WORD;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            illegal_op <= accept & ~opLegal;
            if (issue_en) begin
                if (issueReal) begin
                    instr_out   <= headWord;
                    instr_valid <= 1'b1;
                end else begin
                    instr_out   <= NOP_WORD;
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/instr_issue_unit.md
Name: instr_issue_unit

Overview:
- Issue-side front end for the 8-bit instruction-processing core.
- Accepts decoded instruction fields from a host over a valid/ready handshake and encodes them into the 16-bit instruction word.
- Buffers the words in a FIFO and presents one word per issue cycle on the core's instruction input.
- Acts as the encoder/transmitter for the core's IR/decoder; empty slots are filled with a harmless NOP.

Parameters:
- DEPTH, 8: FIFO entries; power of 2, >= 2.
- NOP_WORD, 16'h8000: word issued when nothing valid is available (ori R0,R0,0; R0 unchanged).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- in_valid  in  1  host presents an instruction.
- in_ready  out  1  = (count != DEPTH); combinational from registered count.
- in_op  in  3  opcode: 000 add, 001 sub, 010 addi, 011 andi, 100 ori.
- in_rs  in  3  source register.
- in_rt  in  3  second source (R-type) or destination (I-type).
- in_rd  in  3  destination (R-type only).
- in_imm  in  6  immediate (I-type only).
- issue_en  in  1  core consumes the presented word this cycle.
- flush  in  1  synchronous clear of queue and output.
- instr_out  out  16  registered instruction word to the core.
- instr_valid  out  1  instr_out holds a real queued instruction.
- illegal_op  out  1  one-cycle pulse when an opcode in 101..111 is accepted.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values (reset low):
  - instr_out = NOP_WORD, instr_valid = 0, illegal_op = 0, fifo_count = 0.
  - Pointers = 0, so in_ready = 1.
- Encoding:
  - R-type (000/001) = {op, rs, rt, rd, 4'b0000}.
  - I-type (010/011/100) = {op, rs, rt, 1'b0, imm}; bit 6 is always 0.
- Push: occurs when in_valid & in_ready at a posedge.
  - Legal opcode: the encoded word is written at wr_ptr and count increments.
  - Illegal opcode: the handshake still completes but nothing is written; illegal_op = 1 for exactly the next cycle.
- Issue: at a posedge with issue_en = 1:
  - If count > 0: instr_out <= head, instr_valid <= 1, pop.
  - Otherwise: instr_out <= NOP_WORD, instr_valid <= 0.
- issue_en = 0: instr_out and instr_valid hold.
- Latency: no bypass. A word pushed at edge N is issuable at the earliest at edge N+1. Push and issue on the same edge into an empty FIFO issues NOP.
- Simultaneous push and pop: count is unchanged; both pointers advance (mod DEPTH, wrap-around).
- Full: in_ready = 0 even when a pop happens in the same cycle; there is no push-through-when-full.
- Flush has priority over push and issue:
  - Pointers and count cleared.
  - instr_out <= NOP_WORD, instr_valid <= 0.
  - A concurrent push is discarded, and a concurrent illegal_op pulse is suppressed.
- Reset asserted mid-operation discards all queued words with no partial state. The first edge after release behaves as from an empty FIFO.
- Order: strictly FIFO; words are never reordered or duplicated.

Optional Feature:
- Macro: INSTR_ISSUE_HAZARD_BUBBLE_EN.
- Enabled: the unit tracks the destination of the last issued valid word (rd for R-type, rt for I-type) and a last_dst_vld flag.
  - On an issue cycle, if last_dst_vld is set and the head reads that register, NOP_WORD is issued with instr_valid = 0 and no pop.
  - "Reads" means rs for any opcode, or rt for R-type.
  - last_dst_vld is cleared after any NOP issue; flush and reset also clear it.
- Disabled: no tracking; back-to-back issue with no bubble.

Decomposition:
- Package instr_issue_pkg holds:
  - opcode localparams (OP_ADD..OP_ORI);
  - field bit positions;
  - NOP_WORD default;
  - an encode function (fields to 16-bit word);
  - functions is_rtype and dst_of.
- Sub-module instr_fifo: DEPTH x 16 storage, pointers, count, full/empty, and flush.
- Top level: encode/legality check, output register, optional hazard logic.

Test Plan:
1. Reset low mid-stream, then release -> instr_out = 16'h8000, instr_valid = 0, fifo_count = 0, in_ready = 1; queued words never appear.
2. Push addi rs0 rt0 imm6, ori rs2 rt7 imm63, and sub rs0 rt1 rd5, with issue_en = 1 -> instr_out sequence 16'h4006, 16'h8BBF, 16'h20D0, each with instr_valid = 1, then 16'h8000 with instr_valid = 0.
3. issue_en = 0, push 9 legal words -> in_ready drops after the 8th, the 9th is not accepted, fifo_count = 8. Then issue_en = 1 -> the 8 words come out in order across the pointer wrap, then NOP.
4. Push op = 3'b110 -> illegal_op high for exactly 1 cycle, fifo_count unchanged; the next legal push still issues correctly.
5. Queue 3 words, assert flush together with in_valid -> fifo_count = 0, instr_out = 16'h8000, instr_valid = 0, the pushed word is lost.
6. With INSTR_ISSUE_HAZARD_BUBBLE_EN, push 16'h4006 then R-type reading R0 (16'h20D0) -> issue sequence 16'h4006, 16'h8000 (instr_valid = 0), 16'h20D0. Without the macro -> 16'h4006, 16'h20D0 back-to-back.
